// File: rtl/stream_store_sched_if.sv
// Command, engine-handshake and status signals of the store scheduler.
// master = scheduler side, slave = command source plus burst/residual engines.
interface stream_store_sched_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned LEN_W  = 32
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              burst_start;
    logic              burst_ready;
    logic              burst_done;
    logic [ADDR_W-1:0] burst_addr;
    logic              res_start;
    logic              res_ready;
    logic              res_done;
    logic [ADDR_W-1:0] res_addr;
    logic [LEN_W-1:0]  res_len;
    logic              done;
    logic              busy;
    logic [31:0]       stat_bursts;
    logic [31:0]       stat_cycles;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, burst_ready, burst_done, res_ready, res_done,
        output cmd_ready, burst_start, burst_addr, res_start, res_addr, res_len, done, busy,
               stat_bursts, stat_cycles
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, burst_ready, burst_done, res_ready, res_done,
        input  cmd_ready, burst_start, burst_addr, res_start, res_addr, res_len, done, busy,
               stat_bursts, stat_cycles
    );
endinterface

// File: rtl/stream_store_sched.sv
// Splits a store command into full bursts plus one residual transfer and sequences
// the burst-loop and residual-loop engines one at a time.
module stream_store_sched #(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned LEN_W      = 32,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned WORD_BYTES = 4
) (
    input logic                  clock,
    input logic                  reset,
    stream_store_sched_if.master bus
);

    localparam int unsigned       BurstShift = $clog2(BURST_LEN);
    localparam logic [LEN_W-1:0]  RlMask     = LEN_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] BurstBytes = ADDR_W'(BURST_LEN * WORD_BYTES);

    typedef enum logic [2:0] {
        StIdle,
        StBIssue,
        StBWait,
        StRIssue,
        StRWait,
        StFin
    } state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  nb_q, nb_d;
    logic [LEN_W-1:0]  rl_q, rl_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       bursts_q, bursts_d;
    logic [31:0]       cycles_q, cycles_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            nb_q     <= '0;
            rl_q     <= '0;
            addr_q   <= '0;
            bursts_q <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            nb_q     <= nb_d;
            rl_q     <= rl_d;
            addr_q   <= addr_d;
            bursts_q <= bursts_d;
            cycles_q <= cycles_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        nb_d     = nb_q;
        rl_d     = rl_q;
        addr_d   = addr_q;
        bursts_d = bursts_q;
        cycles_d = cycles_q;

        // Saturating cycle count over every busy state except FIN.
        if (state_q != StIdle && state_q != StFin && cycles_q != '1) begin
            cycles_d = cycles_q + 32'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    nb_d     = bus.cmd_len >> BurstShift;
                    rl_d     = bus.cmd_len & RlMask;
                    addr_d   = bus.cmd_addr;
                    bursts_d = '0;
                    cycles_d = '0;
                    if ((bus.cmd_len >> BurstShift) != '0) begin
                        state_d = StBIssue;
                    end else if ((bus.cmd_len & RlMask) != '0) begin
                        state_d = StRIssue;
                    end else begin
                        state_d = StFin;
                    end
                end
            end
            StBIssue: begin
                if (bus.burst_ready) begin
                    state_d  = StBWait;
                    bursts_d = bursts_q + 32'd1;
                end
            end
            StBWait: begin
                if (bus.burst_done) begin
                    addr_d = addr_q + BurstBytes;
                    nb_d   = nb_q - LEN_W'(1);
                    if (nb_q > LEN_W'(1)) begin
                        state_d = StBIssue;
                    end else if (rl_q != '0) begin
                        state_d = StRIssue;
                    end else begin
                        state_d = StFin;
                    end
                end
            end
            StRIssue: begin
                if (bus.res_ready) begin
                    state_d = StRWait;
                end
            end
            StRWait: begin
                if (bus.res_done) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.cmd_ready   = (state_q == StIdle);
    assign bus.burst_start = (state_q == StBIssue);
    assign bus.res_start   = (state_q == StRIssue);
    assign bus.done        = (state_q == StFin);
    assign bus.busy        = (state_q != StIdle);
    assign bus.burst_addr  = addr_q;
    assign bus.res_addr    = addr_q;
    assign bus.res_len     = rl_q;
    assign bus.stat_bursts = bursts_q;
    assign bus.stat_cycles = cycles_q;

endmodule

// File: tb/tb_stream_store_sched.sv
// Directed bench for stream_store_sched: each command is driven by hand and the
// engines' responses are scripted so addresses, pulses and statistics are known exactly.
module tb_stream_store_sched;

    logic clock = 1'b0;
    logic reset = 1'b1;

    stream_store_sched_if #(.ADDR_W(64), .LEN_W(32)) bus ();

    stream_store_sched #(
        .ADDR_W    (64),
        .LEN_W     (32),
        .BURST_LEN (16),
        .WORD_BYTES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    logic burst_seen = 1'b0;
    logic res_seen   = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clock) begin
        if (bus.done === 1'b1) done_cnt++;
        if (bus.burst_start === 1'b1) burst_seen = 1'b1;
        if (bus.res_start === 1'b1) res_seen = 1'b1;
    end

    always @(negedge clock) begin
        if (!reset) check("mutex", 64'(bus.burst_start & bus.res_start), 64'd0);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic accept(input logic [63:0] addr, input logic [31:0] len);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // Waits for burst_start, checks its address, then handshakes with one wait cycle.
    task automatic serve_burst(input string tag, input logic [63:0] exp_addr);
        int n = 0;
        while (bus.burst_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_start"}, 64'(bus.burst_start), 64'd1);
        check({tag, "_addr"}, bus.burst_addr, exp_addr);
        bus.burst_ready = 1'b1;
        tick();
        bus.burst_ready = 1'b0;
        check({tag, "_drop"}, 64'(bus.burst_start), 64'd0);
        tick();
        bus.burst_done = 1'b1;
        tick();
        bus.burst_done = 1'b0;
    endtask

    task automatic serve_res(input string tag, input logic [63:0] exp_addr,
                             input logic [31:0] exp_len);
        int n = 0;
        while (bus.res_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_start"}, 64'(bus.res_start), 64'd1);
        check({tag, "_addr"}, bus.res_addr, exp_addr);
        check({tag, "_len"}, 64'(bus.res_len), 64'(exp_len));
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        tick();
        bus.res_done = 1'b1;
        tick();
        bus.res_done = 1'b0;
    endtask

    initial begin
        int d0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_addr    = '0;
        bus.cmd_len     = '0;
        bus.burst_ready = 1'b0;
        bus.burst_done  = 1'b0;
        bus.res_ready   = 1'b0;
        bus.res_done    = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_burst_addr", bus.burst_addr, 64'd0);
        check("rst_res_len", 64'(bus.res_len), 64'd0);
        check("rst_stats", {bus.stat_bursts, bus.stat_cycles}, 64'd0);

        // Spurious handshakes in IDLE go nowhere.
        bus.burst_ready = 1'b1;
        bus.burst_done  = 1'b1;
        bus.res_done    = 1'b1;
        tick();
        bus.burst_ready = 1'b0;
        bus.burst_done  = 1'b0;
        bus.res_done    = 1'b0;
        check("idle_spurious", 64'(bus.busy), 64'd0);

        // 40 words: bursts at 0x1000, 0x1040, residual of 8 at 0x1080.
        d0 = done_cnt;
        accept(64'h1000, 32'd40);
        check("t1_busy", 64'(bus.busy), 64'd1);
        serve_burst("t1_b0", 64'h1000);
        serve_burst("t1_b1", 64'h1040);
        serve_res("t1_r", 64'h1080, 32'd8);
        check("t1_done", 64'(bus.done), 64'd1);
        check("t1_fin_ready", 64'(bus.cmd_ready), 64'd0);
        tick();
        check("t1_done_pulse", 64'(bus.done), 64'd0);
        check("t1_idle_ready", 64'(bus.cmd_ready), 64'd1);
        check("t1_bursts", 64'(bus.stat_bursts), 64'd2);
        check("t1_cycles", 64'(bus.stat_cycles), 64'd9);
        tick();
        check("t1_cycles_hold", 64'(bus.stat_cycles), 64'd9);
        check("t1_done_cnt", 64'(done_cnt - d0), 64'd1);

        // 32 words: exact multiple, no residual, done right after second burst_done.
        res_seen = 1'b0;
        accept(64'h2000, 32'd32);
        serve_burst("t2_b0", 64'h2000);
        serve_burst("t2_b1", 64'h2040);
        check("t2_done", 64'(bus.done), 64'd1);
        tick();
        check("t2_no_res", 64'(res_seen), 64'd0);
        check("t2_bursts", 64'(bus.stat_bursts), 64'd2);

        // 5 words: residual only.
        burst_seen = 1'b0;
        accept(64'h3000, 32'd5);
        check("t3_no_bstart", 64'(bus.burst_start), 64'd0);
        serve_res("t3_r", 64'h3000, 32'd5);
        check("t3_done", 64'(bus.done), 64'd1);
        tick();
        check("t3_no_burst", 64'(burst_seen), 64'd0);
        check("t3_bursts", 64'(bus.stat_bursts), 64'd0);

        // Zero length: straight to FIN, no engine start.
        d0 = done_cnt;
        accept(64'h3100, 32'd0);
        check("t4_done", 64'(bus.done), 64'd1);
        check("t4_starts", 64'({bus.burst_start, bus.res_start}), 64'd0);
        tick();
        check("t4_done_pulse", 64'(bus.done), 64'd0);
        check("t4_cycles", 64'(bus.stat_cycles), 64'd0);
        check("t4_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Back-pressure: burst_ready low 10 cycles, spurious burst_done in B_ISSUE.
        accept(64'h4000, 32'd16);
        for (int i = 0; i < 10; i++) begin
            bus.burst_done = (i == 3);
            bus.res_ready  = (i == 5);
            tick();
        end
        bus.burst_done = 1'b0;
        bus.res_ready  = 1'b0;
        check("t5_hold_start", 64'(bus.burst_start), 64'd1);
        check("t5_hold_addr", bus.burst_addr, 64'h4000);
        check("t5_stall_cycles", 64'(bus.stat_cycles), 64'd10);
        check("t5_no_bursts", 64'(bus.stat_bursts), 64'd0);
        bus.burst_ready = 1'b1;
        tick();
        bus.burst_ready = 1'b0;
        bus.burst_done  = 1'b1;
        tick();
        bus.burst_done = 1'b0;
        check("t5_done", 64'(bus.done), 64'd1);
        check("t5_cycles", 64'(bus.stat_cycles), 64'd12);
        tick();
        check("t5_bursts", 64'(bus.stat_bursts), 64'd1);

        // Reset during B_WAIT: outputs clear without a clock edge, no done.
        d0 = done_cnt;
        accept(64'h5000, 32'd32);
        bus.burst_ready = 1'b1;
        tick();
        bus.burst_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("t6_rst_busy", 64'(bus.busy), 64'd0);
        check("t6_rst_starts", 64'({bus.burst_start, bus.res_start, bus.done}), 64'd0);
        check("t6_rst_addr", bus.burst_addr, 64'd0);
        check("t6_rst_stats", {bus.stat_bursts, bus.stat_cycles}, 64'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check("t6_ready", 64'(bus.cmd_ready), 64'd1);
        check("t6_no_done", 64'(done_cnt - d0), 64'd0);
        accept(64'h6000, 32'd16);
        serve_burst("t6_b0", 64'h6000);
        check("t6_done", 64'(bus.done), 64'd1);
        tick();

        // Address wrap at the top of the 64-bit space.
        accept(64'hFFFF_FFFF_FFFF_FFC0, 32'd32);
        serve_burst("t7_b0", 64'hFFFF_FFFF_FFFF_FFC0);
        serve_burst("t7_b1", 64'd0);
        check("t7_done", 64'(bus.done), 64'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
